// File: rtl/sram_weight_reader_if.sv
// Output beat stream of the SRAM weight reader: one 64-bit beat per transfer.
// A beat moves on any clock edge where out_valid and out_ready are both high.
interface sram_weight_reader_if;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  out_keep;
    logic        out_last;

    modport master (output out_valid, out_data, out_keep, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_keep, out_last, output out_ready);
endinterface

// File: rtl/sram_weight_reader.sv
// Bursts 32-bit weight words out of a dual-port SRAM two at a time into a small
// output FIFO, issuing reads only when buffer space is guaranteed for the return.
module sram_weight_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [14:0] length,
    output logic        busy,
    output logic        done,
    output logic        sram_cen,
    output logic [3:0]  sram_wea0,
    output logic [3:0]  sram_wea1,
    output logic [15:0] sram_addr0,
    output logic [15:0] sram_addr1,
    output logic [31:0] sram_wdata0,
    output logic [31:0] sram_wdata1,
    input  logic [31:0] sram_rdata0,
    input  logic [31:0] sram_rdata1,
    sram_weight_reader_if.master stream
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_next;

    logic [13:0] next_addr;
    logic [13:0] beats_rem;
    logic        odd_tail;
    logic        issue, load, done_next;

    logic        vld_p0, last_p0;
    logic [1:0]  keep_p0;
    logic        vld_p1, last_p1;
    logic [1:0]  keep_p1;

    logic [66:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic [66:0]      head;
    logic             push, pop;
    logic             unused_base_hi;

    assign unused_base_hi = ^base_addr[15:14];

    assign busy        = (state != IDLE);
    assign sram_wea0   = 4'b0000;
    assign sram_wea1   = 4'b0000;
    assign sram_wdata0 = 32'h0;
    assign sram_wdata1 = 32'h0;

    // Space already promised: buffered beats plus reads still in the SRAM pipe.
    assign credit_used = {1'b0, fifo_count}
                       + {{CNT_W{1'b0}}, vld_p0}
                       + {{CNT_W{1'b0}}, vld_p1};

    assign head             = fifo_mem[rd_ptr];
    assign stream.out_valid = (fifo_count != '0);
    assign stream.out_data  = stream.out_valid ? head[63:0]  : 64'h0;
    assign stream.out_keep  = stream.out_valid ? head[65:64] : 2'b00;
    assign stream.out_last  = stream.out_valid ? head[66]    : 1'b0;
    assign pop              = stream.out_valid & stream.out_ready;
    assign push             = vld_p1;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        load       = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (length == 15'd0) begin
                        done_next = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (credit_used < DEPTH_C) begin
                    issue = 1'b1;
                    if (beats_rem == 14'd1) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head[66]) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done       <= 1'b0;
            sram_cen   <= 1'b1;
            sram_addr0 <= 16'h0;
            sram_addr1 <= 16'h0;
            next_addr  <= 14'h0;
            beats_rem  <= 14'h0;
            odd_tail   <= 1'b0;
            vld_p0     <= 1'b0;
            last_p0    <= 1'b0;
            keep_p0    <= 2'b00;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            keep_p1    <= 2'b00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            done     <= done_next;
            sram_cen <= ~issue;
            if (load) begin
                next_addr <= base_addr[13:0];
                beats_rem <= length[14:1] + {13'h0, length[0]};
                odd_tail  <= length[0];
            end
            // p0: issue cycle, addresses presented to the SRAM
            vld_p0 <= issue;
            if (issue) begin
                sram_addr0 <= {2'b00, next_addr};
                sram_addr1 <= {2'b00, next_addr + 14'd1};
                next_addr  <= next_addr + 14'd2;
                beats_rem  <= beats_rem - 14'd1;
                last_p0    <= (beats_rem == 14'd1);
                keep_p0    <= ((beats_rem == 14'd1) && odd_tail) ? 2'b01 : 2'b11;
            end
            // p1: SRAM returns data, captured into the FIFO at the end of this cycle
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
            keep_p1 <= keep_p0;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {last_p1, keep_p1,
                                 keep_p1[1] ? sram_rdata1 : 32'h0, sram_rdata0};
        end
    end
endmodule

// File: tb/tb_sram_weight_reader.sv
// Scoreboard bench for sram_weight_reader: an SRAM model returns word[i]=i and
// expected beats are queued when each burst is started.
module tb_sram_weight_reader;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [15:0] base_addr;
    logic [14:0] length;
    logic        busy, done, sram_cen;
    logic [3:0]  sram_wea0, sram_wea1;
    logic [15:0] sram_addr0, sram_addr1;
    logic [31:0] sram_wdata0, sram_wdata1;
    logic [31:0] sram_rdata0 = 32'h0;
    logic [31:0] sram_rdata1 = 32'h0;

    sram_weight_reader_if stream_if();

    sram_weight_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .sram_cen(sram_cen),
        .sram_wea0(sram_wea0), .sram_wea1(sram_wea1),
        .sram_addr0(sram_addr0), .sram_addr1(sram_addr1),
        .sram_wdata0(sram_wdata0), .sram_wdata1(sram_wdata1),
        .sram_rdata0(sram_rdata0), .sram_rdata1(sram_rdata1),
        .stream(stream_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_cen) begin
            sram_rdata0 <= {16'h0, sram_addr0};
            sram_rdata1 <= {16'h0, sram_addr1};
        end
    end

    typedef struct {
        logic [63:0] data;
        logic [1:0]  keep;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic push_expected(input int b, input int len);
        int nb, a0, a1;
        beat_t e;
        nb = (len + 1) / 2;
        for (int k = 0; k < nb; k++) begin
            a0 = ((b % 16384) + 2 * k) % 16384;
            a1 = (a0 + 1) % 16384;
            e.last = (k == nb - 1);
            if (e.last && (len % 2 == 1)) begin
                e.data = {32'h0, a0};
                e.keep = 2'b01;
            end else begin
                e.data = {a1, a0};
                e.keep = 2'b11;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = 16'h0; length = 15'h0;
        stream_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, stream_if.out_valid, stream_if.out_last} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got busy,done,valid,last=%b want 0000",
                     {busy, done, stream_if.out_valid, stream_if.out_last});
        end
        checks++;
        if ({stream_if.out_keep, stream_if.out_data} !== 66'h0) begin
            errors++;
            $display("FAIL reset_data got keep=%b data=%h want 0", stream_if.out_keep, stream_if.out_data);
        end
        checks++;
        if ({sram_cen, sram_addr0, sram_addr1} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_sram got cen=%b a0=%0d a1=%0d want cen=1 a0=0 a1=0",
                     sram_cen, sram_addr0, sram_addr1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int first_valid = 0, last_cyc = 0, done_cyc = 0, done_cnt = 0;
        beat_t e;
        push_expected(0, 8);
        stream_if.out_ready = 1'b1;
        base_addr = 16'd0; length = 15'd8; start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
            end
            if (stream_if.out_valid && first_valid == 0) first_valid = c;
            if (stream_if.out_valid && stream_if.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL basic_extra got data=%h want no beat", stream_if.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({stream_if.out_data, stream_if.out_keep, stream_if.out_last} !== {e.data, e.keep, e.last}) begin
                        errors++;
                        $display("FAIL basic_beat got %h/%b/%b want %h/%b/%b", stream_if.out_data,
                                 stream_if.out_keep, stream_if.out_last, e.data, e.keep, e.last);
                    end
                end
                if (stream_if.out_last) last_cyc = c;
            end
            if (done) begin
                done_cnt++; done_cyc = c;
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
            end
        end
        checks++;
        if (first_valid != 4) begin errors++; $display("FAIL basic_latency got %0d want 4", first_valid); end
        checks++;
        if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
            errors++; $display("FAIL basic_done got count=%0d at %0d want 1 at %0d", done_cnt, done_cyc, last_cyc + 1);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        logic [31:0] addr_q[$];
        logic [31:0] ea;
        int done_cnt = 0;
        beat_t e;
        exp_q.delete();
        push_expected(16382, 4);
        addr_q.push_back({16'd16382, 16'd16383});
        addr_q.push_back({16'd0, 16'd1});
        base_addr = 16'hFFFE; length = 15'd4; start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (!sram_cen) begin
                checks++;
                ea = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hFFFF_FFFF;
                if ({sram_addr0, sram_addr1, sram_wea0, sram_wea1, sram_wdata0, sram_wdata1} !== {ea, 72'h0}) begin
                    errors++;
                    $display("FAIL wrap_addr got a0=%0d a1=%0d wea=%b%b want a0=%0d a1=%0d wea=0",
                             sram_addr0, sram_addr1, sram_wea0, sram_wea1, ea[31:16], ea[15:0]);
                end
            end
            if (stream_if.out_valid && stream_if.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL wrap_extra got data=%h want no beat", stream_if.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({stream_if.out_data, stream_if.out_keep, stream_if.out_last} !== {e.data, e.keep, e.last}) begin
                        errors++;
                        $display("FAIL wrap_beat got %h/%b/%b want %h/%b/%b", stream_if.out_data,
                                 stream_if.out_keep, stream_if.out_last, e.data, e.keep, e.last);
                    end
                end
            end
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt != 1 || exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++; $display("FAIL wrap_end got done=%0d beats_left=%0d issues_left=%0d want 1/0/0",
                               done_cnt, exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_odd_tail();
        int done_cnt = 0, n = 0;
        beat_t e;
        exp_q.delete();
        push_expected(10, 5);
        base_addr = 16'd10; length = 15'd5; start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (stream_if.out_valid && stream_if.out_ready) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL odd_extra got data=%h want no beat", stream_if.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({stream_if.out_data, stream_if.out_keep, stream_if.out_last} !== {e.data, e.keep, e.last}) begin
                        errors++;
                        $display("FAIL odd_beat%0d got %h/%b/%b want %h/%b/%b", n, stream_if.out_data,
                                 stream_if.out_keep, stream_if.out_last, e.data, e.keep, e.last);
                    end
                end
            end
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt != 1 || n != 3) begin
            errors++; $display("FAIL odd_end got done=%0d beats=%0d want 1/3", done_cnt, n);
        end
    endtask

    task automatic test_backpressure();
        int issued = 0, done_cnt = 0, n = 0;
        logic stalled = 1'b0;
        logic [66:0] prev = '0;
        beat_t e;
        exp_q.delete();
        push_expected(200, 32);
        stream_if.out_ready = 1'b0;
        base_addr = 16'd200; length = 15'd32; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (!sram_cen) issued++;
            if (stalled) begin
                checks++;
                if ({stream_if.out_valid, stream_if.out_last, stream_if.out_keep, stream_if.out_data} !== {1'b1, prev}) begin
                    errors++; $display("FAIL stall_hold got %h want %h",
                                       {stream_if.out_last, stream_if.out_keep, stream_if.out_data}, prev);
                end
            end
            stalled = stream_if.out_valid;
            prev = {stream_if.out_last, stream_if.out_keep, stream_if.out_data};
            if (c >= 12) begin
                checks++;
                if (sram_cen !== 1'b1) begin errors++; $display("FAIL stall_cen cycle %0d got %b want 1", c, sram_cen); end
            end
            if (c == 7) begin
                base_addr = 16'd3000; length = 15'd3; start = 1'b1;
            end
        end
        checks++;
        if (issued != DEPTH) begin errors++; $display("FAIL stall_issues got %0d want %0d", issued, DEPTH); end
        stalled = 1'b0;
        for (int c = 1; c <= 200 && done_cnt == 0; c++) begin
            stream_if.out_ready = ($urandom_range(0, 3) != 0);
            if (stalled) begin
                checks++;
                if ({stream_if.out_last, stream_if.out_keep, stream_if.out_data} !== prev) begin
                    errors++; $display("FAIL drain_hold got %h want %h",
                                       {stream_if.out_last, stream_if.out_keep, stream_if.out_data}, prev);
                end
            end
            stalled = stream_if.out_valid && !stream_if.out_ready;
            prev = {stream_if.out_last, stream_if.out_keep, stream_if.out_data};
            if (stream_if.out_valid && stream_if.out_ready) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL drain_extra got data=%h want no beat", stream_if.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({stream_if.out_data, stream_if.out_keep, stream_if.out_last} !== {e.data, e.keep, e.last}) begin
                        errors++;
                        $display("FAIL drain_beat%0d got %h/%b/%b want %h/%b/%b", n, stream_if.out_data,
                                 stream_if.out_keep, stream_if.out_last, e.data, e.keep, e.last);
                    end
                end
            end
            @(negedge clk);
            if (done) done_cnt++;
        end
        stream_if.out_ready = 1'b1;
        checks++;
        if (done_cnt != 1 || n != 16 || exp_q.size() != 0) begin
            errors++; $display("FAIL drain_end got done=%0d beats=%0d left=%0d want 1/16/0", done_cnt, n, exp_q.size());
        end
    endtask

    task automatic test_zero_length();
        int cen_low = 0, valid_seen = 0, busy_seen = 0, done_cnt = 0, done_cyc = 0;
        base_addr = 16'd55; length = 15'd0; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (!sram_cen) cen_low++;
            if (stream_if.out_valid) valid_seen++;
            if (busy) busy_seen++;
            if (done) begin done_cnt++; done_cyc = c; end
        end
        checks++;
        if (cen_low != 0 || valid_seen != 0 || busy_seen != 0) begin
            errors++; $display("FAIL zero_quiet got cen_low=%0d valid=%0d busy=%0d want 0/0/0",
                               cen_low, valid_seen, busy_seen);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 1) begin
            errors++; $display("FAIL zero_done got count=%0d at %0d want 1 at 1", done_cnt, done_cyc);
        end
    endtask

    task automatic test_abort();
        int done_cnt = 0, n = 0;
        beat_t e;
        exp_q.delete();
        base_addr = 16'd500; length = 15'd40; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, busy, stream_if.out_valid, sram_cen} !== 4'b0001) begin
            errors++; $display("FAIL abort_reset got done,busy,valid,cen=%b want 0001",
                               {done, busy, stream_if.out_valid, sram_cen});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({done, stream_if.out_valid} !== 2'b00) begin
            errors++; $display("FAIL abort_after got done,valid=%b want 00", {done, stream_if.out_valid});
        end
        push_expected(100, 2);
        base_addr = 16'd100; length = 15'd2; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (stream_if.out_valid && stream_if.out_ready) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL abort_stale got data=%h want no beat", stream_if.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({stream_if.out_data, stream_if.out_keep, stream_if.out_last} !== {e.data, e.keep, e.last}) begin
                        errors++;
                        $display("FAIL abort_beat got %h/%b/%b want %h/%b/%b", stream_if.out_data,
                                 stream_if.out_keep, stream_if.out_last, e.data, e.keep, e.last);
                    end
                end
            end
            if (done) done_cnt++;
        end
        checks++;
        if (done_cnt != 1 || n != 1) begin
            errors++; $display("FAIL abort_end got done=%0d beats=%0d want 1/1", done_cnt, n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_odd_tail();
        test_backpressure();
        test_zero_length();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_weight_reader.md
SRAM_WEIGHT_READER -- requirements
Module: sram_weight_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output-buffer entries (power of two, min 4).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  one-cycle request to begin a burst; ignored while busy=1.
REQ-005 base_addr  input  16  first word address, sampled with start; bits [15:14] ignored.
REQ-006 length  input  15  number of 32-bit words, 0..16384, sampled with start.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse when the last beat is accepted downstream.
REQ-009 sram_cen  output  1  SRAM chip enable, active-low, shared by both ports.
REQ-010 sram_wea0 / sram_wea1  output  4 each  byte write enables, always 4'b0000.
REQ-011 sram_addr0 / sram_addr1  output  16 each  port word addresses, bits [15:14] always 0.
REQ-012 sram_wdata0 / sram_wdata1  output  32 each  always 32'h0.
REQ-013 sram_rdata0 / sram_rdata1  input  32 each  read data, valid the cycle after an issue cycle.
REQ-014 out_valid  output  1  output beat valid.
REQ-015 out_ready  input  1  downstream accept; a beat transfers when out_valid & out_ready.
REQ-016 out_data  output  64  [31:0]=word at even offset, [63:32]=next word.
REQ-017 out_keep  output  2  per-word valid; 2'b11 except a final odd beat, which is 2'b01.
REQ-018 out_last  output  1  high on the final beat of the burst.

Function
REQ-019 States: IDLE, RUN, DRAIN; start accepted in IDLE only.
REQ-020 IDLE + start, length>0 -> RUN; length=0 -> no SRAM access, done pulses the next cycle, remains IDLE.
REQ-021 SRAM outputs are registered; an issue cycle is a cycle with sram_cen=0; sram_cen=1 in every other cycle.
REQ-022 Issue k (k=0..ceil(length/2)-1): addr0=(base+2k) mod 16384, addr1=(base+2k+1) mod 16384; wrap past 16383 to 0.
REQ-023 Data for an issue cycle is captured from sram_rdata0/1 at the end of the following cycle and pushed into the FIFO with keep and last.
REQ-024 Final odd beat: port 1 is still read, but out_data[63:32]=0 and out_keep=2'b01.
REQ-025 Credit rule: issue only when fifo_count + in_flight + 1 <= FIFO_DEPTH (pops in the same cycle not credited); captured data is never dropped.
REQ-026 With out_ready held high, issue continues every cycle (one 64-bit beat per cycle sustained).
REQ-027 Latency: with an empty FIFO, the first out_valid is exactly 3 cycles after the start-sampling edge (issue, SRAM, capture).
REQ-028 RUN -> DRAIN after the last issue; DRAIN -> IDLE with done=1 in the cycle after the out_last beat transfers; busy drops in that same cycle.
REQ-029 out_data/keep/last stay stable while out_valid=1 and out_ready=0.
REQ-030 start during RUN/DRAIN has no effect on any output.

Reset
REQ-031 While rst_n=0 at a clock edge: state=IDLE, FIFO and in-flight cleared, busy=0, done=0, out_valid=0, out_last=0, out_keep=0, out_data=0, sram_cen=1, addresses=0.
REQ-032 Reset mid-burst aborts it with no done pulse; returned SRAM data still in flight is discarded.

Verification
REQ-033 SRAM preloaded with word[i]=i; start base=0, length=8, out_ready=1 -> 4 beats 64'h00000001_00000000 .. 64'h00000007_00000006, keep=11, last on beat 4, done next cycle.
REQ-034 base=16382, length=4 -> addresses 16382/16383 then 0/1; beats {16383,16382}, {1,0}.
REQ-035 base=10, length=5 -> third beat data=64'h00000000_0000000E, keep=01, last=1.
REQ-036 out_ready=0 for 20 cycles after start, length=32 -> at most FIFO_DEPTH beats buffered, sram_cen held 1 once credits are exhausted; after release all 16 beats arrive in order, none lost or duplicated.
REQ-037 length=0 -> sram_cen never 0, out_valid never 1, done pulses once.
REQ-038 rst_n=0 mid-burst, then a new start base=100, length=2 -> only beat {101,100} with last=1; no stale data from the aborted burst appears.
